// File: rtl/lab2_timer_ctrl_if.sv
// Control/status bundle for lab2_timer_ctrl.
//   master : drives SET, D_TENS, D_ONES, START, PAUSE, UP; observes TENS, ONES, BUSY, DONE, ALARM
//   slave  : the timer itself (inputs/outputs mirrored)
interface lab2_timer_ctrl_if;
  localparam int unsigned DIGIT_W = 4;

  logic               SET;
  logic [DIGIT_W-1:0] D_TENS;
  logic [DIGIT_W-1:0] D_ONES;
  logic               START;
  logic               PAUSE;
  logic               UP;
  logic [DIGIT_W-1:0] TENS;
  logic [DIGIT_W-1:0] ONES;
  logic               BUSY;
  logic               DONE;
  logic               ALARM;

  modport master (
    output SET, D_TENS, D_ONES, START, PAUSE, UP,
    input  TENS, ONES, BUSY, DONE, ALARM
  );

  modport slave (
    input  SET, D_TENS, D_ONES, START, PAUSE, UP,
    output TENS, ONES, BUSY, DONE, ALARM
  );
endinterface

// File: rtl/lab2_timer_ctrl.sv
// Two-digit BCD up/down timer with prescaled count steps.
//   CLK  : rising-edge clock
//   CLR  : asynchronous active-low reset
//   bus  : slave side of lab2_timer_ctrl_if
//          SET/D_TENS/D_ONES preset load, START/PAUSE run control, UP direction,
//          TENS/ONES registered count, BUSY (RUN), DONE (first FIN cycle), ALARM (FIN)
module lab2_timer_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  lab2_timer_ctrl_if.slave  bus
);
  localparam int unsigned DW = 4;
  localparam int unsigned PW = 8;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, FIN} state_t;

  state_t        state_q;
  logic [DW-1:0] tens_q, ones_q;
  logic [PW-1:0] presc_q;
  logic          busy_q, done_q, alarm_q;

  logic [DW-1:0] nxt_tens_c, nxt_ones_c;
  logic          cur_term_c, nxt_term_c;

  // Saturate out-of-range preset digits to 9.
  function automatic logic [DW-1:0] clamp9(input logic [DW-1:0] d);
    return (d > DW'(9)) ? DW'(9) : d;
  endfunction

  // Candidate count after one step in the current direction; never wraps 00<->99.
  always_comb begin
    nxt_tens_c = tens_q;
    nxt_ones_c = ones_q;
    if (bus.UP) begin
      if (ones_q == DW'(9)) begin
        if (tens_q != DW'(9)) begin
          nxt_ones_c = '0;
          nxt_tens_c = tens_q + DW'(1);
        end
      end else begin
        nxt_ones_c = ones_q + DW'(1);
      end
    end else begin
      if (ones_q == DW'(0)) begin
        if (tens_q != DW'(0)) begin
          nxt_ones_c = DW'(9);
          nxt_tens_c = tens_q - DW'(1);
        end
      end else begin
        nxt_ones_c = ones_q - DW'(1);
      end
    end
    cur_term_c = bus.UP ? ((tens_q == DW'(9)) && (ones_q == DW'(9)))
                        : ((tens_q == DW'(0)) && (ones_q == DW'(0)));
    nxt_term_c = bus.UP ? ((nxt_tens_c == DW'(9)) && (nxt_ones_c == DW'(9)))
                        : ((nxt_tens_c == DW'(0)) && (nxt_ones_c == DW'(0)));
  end

  // Control FSM, count and prescaler; status flags track the state they decode.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      tens_q  <= '0;
      ones_q  <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, HOLD: begin
          if (bus.SET) begin
            tens_q <= clamp9(bus.D_TENS);
            ones_q <= clamp9(bus.D_ONES);
          end else if (bus.START) begin
            if (cur_term_c) begin
              state_q <= FIN;
              alarm_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              // A fresh run restarts the step period; a resume keeps it.
              if (state_q == IDLE) presc_q <= '0;
            end
          end
        end
        RUN: begin
          if (bus.PAUSE) begin
            state_q <= HOLD;
            busy_q  <= 1'b0;
          end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            tens_q  <= nxt_tens_c;
            ones_q  <= nxt_ones_c;
            if (nxt_term_c) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              alarm_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        FIN: begin
          if (bus.SET) begin
            tens_q  <= clamp9(bus.D_TENS);
            ones_q  <= clamp9(bus.D_ONES);
            state_q <= IDLE;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TENS  = tens_q;
  assign bus.ONES  = ones_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.ALARM = alarm_q;
endmodule

// File: doc/lab2_timer_ctrl.md
LAB2_TIMER_CTRL -- requirements
Module: lab2_timer_ctrl

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 4, meaning clock cycles per count step (legal range 2..255).
REQ-002 SHALL provide port CLK  input  1  rising-edge system clock, the only clock.
REQ-003 SHALL provide port CLR  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port SET  input  1  load preset from D_TENS/D_ONES.
REQ-005 SHALL provide port D_TENS  input  4  preset tens digit, BCD.
REQ-006 SHALL provide port D_ONES  input  4  preset ones digit, BCD.
REQ-007 SHALL provide port START  input  1  begin or resume counting.
REQ-008 SHALL provide port PAUSE  input  1  suspend counting.
REQ-009 SHALL provide port UP  input  1  count direction: 1 = up toward 99, 0 = down toward 00.
REQ-010 SHALL provide port TENS  output  4  current tens digit, BCD, registered.
REQ-011 SHALL provide port ONES  output  4  current ones digit, BCD, registered.
REQ-012 SHALL provide port BUSY  output  1  high while in RUN.
REQ-013 SHALL provide port DONE  output  1  one-cycle pulse on entry to FIN.
REQ-014 SHALL provide port ALARM  output  1  high while in FIN.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HOLD, FIN; all state, digit and prescaler registers SHALL update on rising CLK only.
REQ-016 In IDLE, HOLD or FIN, SET SHALL load TENS/ONES from D_TENS/D_ONES on the same edge; any digit value >9 SHALL be clamped to 9.
REQ-017 SET in FIN SHALL move to IDLE; SET in HOLD SHALL stay in HOLD; SET in RUN SHALL be ignored.
REQ-018 Priority in IDLE/HOLD: SET > START; with SET and START both high, the load SHALL occur and the state SHALL not change.
REQ-019 START in IDLE or HOLD SHALL move to RUN next edge, unless the count is already terminal (00 with UP=0, 99 with UP=1), in which case it SHALL move to FIN.
REQ-020 A 0..TICK_DIV-1 prescaler SHALL advance only in RUN; a tick SHALL occur in a RUN cycle where the prescaler equals TICK_DIV-1, and the prescaler SHALL then wrap to 0.
REQ-021 The prescaler SHALL clear to 0 on IDLE->RUN and hold its value across RUN->HOLD->RUN.
REQ-022 PAUSE in RUN SHALL move to HOLD; a tick coincident with PAUSE SHALL be suppressed (count unchanged, prescaler holds).
REQ-023 START in RUN and PAUSE/START outside their states SHALL be ignored.
REQ-024 On a down tick: ONES 0 SHALL become 9 with TENS decremented; otherwise ONES decrements; TENS 0 SHALL never be decremented (terminal catches 00).
REQ-025 On an up tick: ONES 9 SHALL become 0 with TENS incremented; otherwise ONES increments.
REQ-026 UP SHALL be sampled on every tick, so a direction change mid-run takes effect at the next tick.
REQ-027 A tick producing the terminal value for the current UP (00 down, 99 up) SHALL move RUN->FIN on that same edge; the count SHALL never wrap 00<->99.
REQ-028 DONE SHALL be high for exactly the first cycle in FIN; ALARM SHALL be high for every FIN cycle; BUSY SHALL equal (state==RUN).
REQ-029 FIN SHALL hold the count; only SET or CLR SHALL leave FIN.
REQ-030 Outputs SHALL be glitch-free registered values or direct decodes of state registers; no combinational path from inputs to outputs.

Reset
REQ-031 CLR low SHALL immediately, independent of CLK, force state IDLE, TENS=0, ONES=0, prescaler=0, BUSY=0, DONE=0, ALARM=0.
REQ-032 CLR asserted mid-RUN or in FIN SHALL abort without any DONE pulse; operation SHALL resume at the first rising CLK after CLR returns high.

Verification
REQ-033 TICK_DIV=4, SET with 0/3, UP=0, START -> BUSY next cycle, count 02,01,00 at RUN cycles 4,8,12; DONE pulse once; ALARM held; BUSY low.
REQ-034 Preset 9/7, UP=1, START -> 98 then 99 -> FIN; no wrap to 00; SET with 1/2 in FIN -> IDLE, count 12, ALARM low.
REQ-035 Preset 2/0 down, PAUSE asserted on the same cycle as the first tick -> HOLD, count stays 20; START -> the tick fires one cycle later, count 19.
REQ-036 Preset 0/0, UP=0, START -> FIN directly, DONE pulse, count 00; SET with D=F/A -> count 99.
REQ-037 Preset 1/0 down, UP toggled to 1 after the first tick -> 09 then 10, 11; CLR pulse mid-RUN -> 00, IDLE, DONE never asserted.
